// File: rtl/reg_bank_wr8_if.sv
// Write-back request channel into the reg_bank_wr8 write queue.
interface reg_bank_wr8_if #(
  parameter int unsigned N = 32
);
  logic         wr_valid;
  logic         wr_ready;
  logic [2:0]   wr_addr;
  logic [N-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/reg_bank_wr8.sv
// Eight-entry register bank fed by a 2-deep in-order write queue; exposes a
// pending-write mask so hazard logic can see uncommitted destinations.
module reg_bank_wr8 #(
  parameter int unsigned N         = 32,
  parameter bit          ZERO_REG0 = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  reg_bank_wr8_if.slave     wr,
  input  logic              bank_hold,
  output logic [N-1:0]      q0,
  output logic [N-1:0]      q1,
  output logic [N-1:0]      q2,
  output logic [N-1:0]      q3,
  output logic [N-1:0]      q4,
  output logic [N-1:0]      q5,
  output logic [N-1:0]      q6,
  output logic [N-1:0]      q7,
  output logic [7:0]        pend_mask,
  output logic [1:0]        wq_count
);

  localparam int unsigned NREG  = 8;
  localparam int unsigned DEPTH = 2;

  logic [N-1:0] regs    [NREG];
  logic [2:0]   wq_addr [DEPTH];
  logic [N-1:0] wq_data [DEPTH];
  logic         head;
  logic         tail;
  logic [1:0]   count;

  logic         push;
  logic         pop;
  logic [2:0]   head_addr;
  logic [N-1:0] head_data;

  assign wr.wr_ready = (count != 2'd2);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (count != 2'd0) && !bank_hold;
  assign head_addr   = wq_addr[head];
  assign head_data   = wq_data[head];
  assign wq_count    = count;

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        wq_addr[i] <= '0;
        wq_data[i] <= '0;
      end
    end else begin
      if (push) begin
        wq_addr[tail] <= wr.wr_addr;
        wq_data[tail] <= wr.wr_data;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= 2'(count + 2'(push) - 2'(pop));
    end
  end

  // Commit the head entry; register 0 ignores writes when hardwired to zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (pop) begin
      for (int r = 0; r < NREG; r++) begin
        if ((head_addr == 3'(r)) && !(ZERO_REG0 && (r == 0))) begin
          regs[r] <= head_data;
        end
      end
    end
  end

  // Occupied slots are the first `count` entries starting at head
  always_comb begin
    pend_mask = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (2'(i) < count) begin
        pend_mask[wq_addr[head + 1'(i)]] = 1'b1;
      end
    end
  end

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule

// File: tb/tb_reg_bank_wr8.sv
// Bench for reg_bank_wr8: two instances (register 0 hardwired / ordinary) share
// one stimulus stream and are compared against a queue-based reference model.
module tb_reg_bank_wr8;

  localparam int unsigned N = 32;

  typedef struct packed {
    logic [2:0]   addr;
    logic [N-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rstn;
  logic bank_hold;

  reg_bank_wr8_if #(.N(N)) wa ();
  reg_bank_wr8_if #(.N(N)) wb ();

  logic [N-1:0] qa [8];
  logic [N-1:0] qb [8];
  logic [7:0]   pend_a, pend_b;
  logic [1:0]   cnt_a, cnt_b;

  assign wb.wr_valid = wa.wr_valid;
  assign wb.wr_addr  = wa.wr_addr;
  assign wb.wr_data  = wa.wr_data;

  reg_bank_wr8 #(.N(N), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .rstn(rstn), .wr(wa), .bank_hold(bank_hold),
    .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]),
    .q4(qa[4]), .q5(qa[5]), .q6(qa[6]), .q7(qa[7]),
    .pend_mask(pend_a), .wq_count(cnt_a)
  );

  reg_bank_wr8 #(.N(N), .ZERO_REG0(1'b0)) dut_n (
    .clk(clk), .rstn(rstn), .wr(wb), .bank_hold(bank_hold),
    .q0(qb[0]), .q1(qb[1]), .q2(qb[2]), .q3(qb[3]),
    .q4(qb[4]), .q5(qb[5]), .q6(qb[6]), .q7(qb[7]),
    .pend_mask(pend_b), .wq_count(cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes in acceptance order plus two register files
  ent_t         mq [$];
  logic [N-1:0] mz [8];
  logic [N-1:0] mn [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) begin
      mz[i] = '0;
      mn[i] = '0;
    end
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] m = 8'h00;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] ep = model_pend();
    chk({tag, ":count_z"}, 64'(cnt_a), 64'(mq.size()));
    chk({tag, ":count_n"}, 64'(cnt_b), 64'(mq.size()));
    chk({tag, ":ready_z"}, 64'(wa.wr_ready), 64'(mq.size() != 2));
    chk({tag, ":ready_n"}, 64'(wb.wr_ready), 64'(mq.size() != 2));
    chk({tag, ":pend_z"}, 64'(pend_a), 64'(ep));
    chk({tag, ":pend_n"}, 64'(pend_b), 64'(ep));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s:qz%0d", tag, i), 64'(qa[i]), 64'(mz[i]));
      chk($sformatf("%s:qn%0d", tag, i), 64'(qb[i]), 64'(mn[i]));
    end
  endtask

  // One clock: model decides push/pop from pre-edge state, then outputs are checked
  task automatic cycle(input string tag);
    bit   do_push, do_pop;
    ent_t e;
    do_push = wa.wr_valid && (mq.size() != 2);
    do_pop  = (mq.size() != 0) && !bank_hold;
    e.addr  = wa.wr_addr;
    e.data  = wa.wr_data;
    @(posedge clk);
    if (do_pop) begin
      ent_t h = mq.pop_front();
      if (h.addr != 3'd0) mz[h.addr] = h.data;
      mn[h.addr] = h.data;
    end
    if (do_push) mq.push_back(e);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [N-1:0] d);
    wa.wr_valid = v;
    wa.wr_addr  = a;
    wa.wr_data  = d;
  endtask

  initial begin
    rstn      = 1'b0;
    bank_hold = 1'b0;
    drive(1'b0, 3'd0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    check_all("reset");

    // Single write to r3
    drive(1'b1, 3'd3, 32'hDEADBEEF);
    cycle("w3_acc");
    chk("w3_pend", 64'(pend_a), 64'h08);
    chk("w3_cnt", 64'(cnt_a), 64'd1);
    drive(1'b0, 3'd0, '0);
    cycle("w3_commit");
    chk("w3_q3", 64'(qa[3]), 64'hDEADBEEF);
    chk("w3_pend0", 64'(pend_a), 64'h00);

    // Hold with back-pressure
    bank_hold = 1'b1;
    drive(1'b1, 3'd1, 32'h11); cycle("hold_a");
    drive(1'b1, 3'd2, 32'h22); cycle("hold_b");
    drive(1'b1, 3'd5, 32'h55); cycle("hold_c");
    chk("hold_cnt", 64'(cnt_a), 64'd2);
    chk("hold_ready", 64'(wa.wr_ready), 64'd0);
    chk("hold_pend", 64'(pend_a), 64'h06);
    cycle("hold_stall");
    bank_hold = 1'b0;
    cycle("rel1");
    chk("rel1_q1", 64'(qa[1]), 64'h11);
    chk("rel1_q2", 64'(qa[2]), 64'h0);
    cycle("rel2");
    chk("rel2_q2", 64'(qa[2]), 64'h22);
    drive(1'b0, 3'd0, '0);
    cycle("rel3");
    chk("rel3_q5", 64'(qa[5]), 64'h55);

    // Register 0 behaviour
    drive(1'b1, 3'd0, 32'hFFFFFFFF); cycle("z_acc");
    chk("z_pend", 64'(pend_a), 64'h01);
    drive(1'b0, 3'd0, '0); cycle("z_commit");
    chk("z_q0_zero", 64'(qa[0]), 64'h0);
    chk("z_q0_norm", 64'(qb[0]), 64'hFFFFFFFF);

    // Same address back-to-back with overlapping push/pop
    drive(1'b1, 3'd7, 32'hA); cycle("s7_a");
    drive(1'b1, 3'd7, 32'hB); cycle("s7_b");
    chk("s7_overlap_cnt", 64'(cnt_a), 64'd1);
    chk("s7_mid_q7", 64'(qa[7]), 64'hA);
    drive(1'b0, 3'd0, '0); cycle("s7_c");
    chk("s7_final_q7", 64'(qa[7]), 64'hB);

    // Reset mid-operation
    drive(1'b1, 3'd4, 32'h1234); cycle("r4_acc");
    drive(1'b0, 3'd0, '0); cycle("r4_commit");
    chk("r4_q4", 64'(qa[4]), 64'h1234);
    bank_hold = 1'b1;
    drive(1'b1, 3'd4, 32'h5555); cycle("r4_q1");
    drive(1'b1, 3'd6, 32'h6666); cycle("r4_q2");
    chk("r4_full", 64'(cnt_a), 64'd2);
    drive(1'b0, 3'd0, '0);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_q4", 64'(qa[4]), 64'h0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_pend", 64'(pend_a), 64'h00);
    chk("rst_ready", 64'(wa.wr_ready), 64'd1);
    check_all("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    bank_hold = 1'b0;
    cycle("post_rst1");
    cycle("post_rst2");
    chk("post_rst_q4", 64'(qa[4]), 64'h0);
    chk("post_rst_q6", 64'(qa[6]), 64'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 32'($urandom()));
      bank_hold = ($urandom_range(0, 3) == 0);
      cycle($sformatf("rnd%0d", k));
    end
    bank_hold = 1'b0;
    drive(1'b0, 3'd0, '0);
    repeat (3) cycle("drain");
    chk("drain_empty", 64'(cnt_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
